// File: rtl/ifetch_queue.sv
// Instruction fetch queue: turns fetch PCs into in-order imem reads, buffers
// returned words with their PCs and hands them to decode; flush discards wrong-path reads.
module ifetch_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            pc_i,
    input  logic                       flush_i,
    output logic                       halt_o,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [31:0]                imem_rdata_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [XLEN-1:0]            dec_pc_o,
    output logic [31:0]                dec_instr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d, count_eff;

    logic [XLEN-1:0] trk_pc_q [MAX_OUT];
    logic [TW-1:0]   trk_wr_q, trk_rd_q;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic [31:0]     occupancy;
    logic            space;
    logic            issue;
    logic            push;
    logic            pop;

    function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] ptr);
        return (ptr == TW'(MAX_OUT - 1)) ? '0 : ptr + TW'(1);
    endfunction

    // A flush empties the FIFO this edge, so the target request sees count as zero.
    always_comb begin
        count_eff = flush_i ? '0 : count_q;
        occupancy = 32'(count_eff) + 32'(outstanding_q);
        space     = (occupancy < 32'(DEPTH)) && (32'(outstanding_q) < 32'(MAX_OUT));
    end

    assign imem_req_o  = rst & space;
    assign imem_addr_o = pc_i;
    assign issue       = imem_req_o & imem_gnt_i;
    assign halt_o      = ~issue;

    assign dec_valid_o = (count_q != '0) & ~flush_i;
    assign dec_pc_o    = fifo_pc_q[rd_ptr_q];
    assign dec_instr_o = fifo_instr_q[rd_ptr_q];
    assign count_o     = count_q;

    assign push = imem_rvalid_i & (drop_q == '0) & ~flush_i;
    assign pop  = dec_valid_o & dec_ready_i;

    always_comb begin
        outstanding_d = outstanding_q + OW'(issue) - OW'(imem_rvalid_i);
        count_d       = count_q + CW'(push) - CW'(pop);
        drop_d        = drop_q;
        if (flush_i) begin
            count_d = '0;
            // Only reads already in flight before this edge are wrong-path.
            drop_d  = outstanding_q - OW'(imem_rvalid_i);
        end else if (imem_rvalid_i && (drop_q != '0)) begin
            drop_d  = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            trk_wr_q      <= '0;
            trk_rd_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (issue)         trk_wr_q <= trk_inc(trk_wr_q);
            if (imem_rvalid_i) trk_rd_q <= trk_inc(trk_rd_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]    <= trk_pc_q[trk_rd_q];
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_OUT; i++) trk_pc_q[i] <= '0;
        end else if (issue) begin
            trk_pc_q[trk_wr_q] <= pc_i;
        end
    end

    a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid_i |-> (outstanding_q != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count_q != CW'(DEPTH)));
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (imem_req_o && !imem_gnt_i) |=> (flush_i || $stable(imem_addr_o)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: imem and fetch models driven per cycle,
// decoded pairs checked against a scoreboard by an independent monitor.
module tb_ifetch_queue;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [XLEN-1:0]   pc_i = '0;
    logic              flush_i = 1'b0;
    logic              halt_o;
    logic              imem_req_o;
    logic [XLEN-1:0]   imem_addr_o;
    logic              imem_gnt_i = 1'b0;
    logic              imem_rvalid_i = 1'b0;
    logic [31:0]       imem_rdata_i = '0;
    logic              dec_valid_o;
    logic              dec_ready_i = 1'b0;
    logic [XLEN-1:0]   dec_pc_o;
    logic [31:0]       dec_instr_o;
    logic [2:0]        count_o;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .halt_o(halt_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } pair_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    pair_t exp_q[$];
    mreq_t mem_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    mem_lat = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_decode(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    // Monitor: every accepted head must match the oldest expected pair.
    always @(negedge clk) begin
        pair_t e;
        if (rst && dec_valid_o && dec_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_decode: got pc=0x%0h instr=0x%0h, expected none",
                         dec_pc_o, dec_instr_o);
            end else begin
                e = exp_q.pop_front();
                check("decode_pc", 64'(dec_pc_o), 64'(e.pc));
                check("decode_instr", 64'(dec_instr_o), 64'(e.instr));
                $display("[TB] decode pc=0x%08h instr=0x%08h", dec_pc_o, dec_instr_o);
            end
        end
    end

    // One clock: sample grant at negedge, then advance fetch PC and drive imem response.
    task automatic step();
        logic        adv;
        logic [31:0] a;
        @(negedge clk);
        adv = rst && imem_req_o && imem_gnt_i;
        a   = imem_addr_o;
        if (adv) mem_q.push_back('{addr: a, due: cyc + mem_lat});
        @(posedge clk);
        #1;
        cyc++;
        if (adv) pc_i = pc_i + 32'd4;
        if (rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = {16'hA5A5, mem_q[0].addr[15:0]};
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b0;
        flush_i = 1'b0; imem_gnt_i = 1'b0; dec_ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        pc_i = start_pc; mem_lat = 1;
        mem_q.delete();
        exp_q.delete();
        steps(2);
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_dec_valid"}, 64'(dec_valid_o), 64'd0);
        check({tag, "_req"}, 64'(imem_req_o), 64'd0);
        check({tag, "_halt"}, 64'(halt_o), 64'd1);
        check({tag, "_dec_pc"}, 64'(dec_pc_o), 64'd0);
        check({tag, "_dec_instr"}, 64'(dec_instr_o), 64'd0);
    endtask

    initial begin
        int k;
        #1 rst = 1'b0;
        #2 check_reset_outputs("reset");

        // Streaming: one PC per cycle, decode on consecutive cycles.
        do_reset(32'h0);
        imem_gnt_i = 1'b1; dec_ready_i = 1'b1;
        expect_decode(32'h0, 32'hA5A5_0000);
        expect_decode(32'h4, 32'hA5A5_0004);
        expect_decode(32'h8, 32'hA5A5_0008);
        expect_decode(32'hC, 32'hA5A5_000C);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stream_halt", 64'(halt_o), 64'd0);
            check("stream_addr", 64'(imem_addr_o), 64'(4 * i));
            step();
        end
        imem_gnt_i = 1'b0;
        steps(2);
        #1;
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(count_o), 64'd0);

        // Back-pressure: decode stalled, queue fills to DEPTH.
        do_reset(32'h100);
        imem_gnt_i = 1'b1; dec_ready_i = 1'b0;
        expect_decode(32'h100, 32'hA5A5_0100);
        expect_decode(32'h104, 32'hA5A5_0104);
        expect_decode(32'h108, 32'hA5A5_0108);
        expect_decode(32'h10C, 32'hA5A5_010C);
        expect_decode(32'h110, 32'hA5A5_0110);
        steps(5);
        #1;
        check("bp_halt", 64'(halt_o), 64'd1);
        check("bp_req", 64'(imem_req_o), 64'd0);
        check("bp_count_full", 64'(count_o), 64'd4);
        dec_ready_i = 1'b1;
        step();
        #1;
        check("bp_count_freed", 64'(count_o), 64'd3);
        check("bp_req_resumed", 64'(imem_req_o), 64'd1);
        step();
        imem_gnt_i = 1'b0;
        steps(4);
        #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_count_empty", 64'(count_o), 64'd0);

        // Grant stall: request and address held until granted.
        do_reset(32'h10);
        dec_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_req", 64'(imem_req_o), 64'd1);
            check("stall_addr", 64'(imem_addr_o), 64'h10);
            check("stall_halt", 64'(halt_o), 64'd1);
            step();
        end
        imem_gnt_i = 1'b1;
        expect_decode(32'h10, 32'hA5A5_0010);
        #1;
        check("stall_granted_halt", 64'(halt_o), 64'd0);
        step();
        imem_gnt_i = 1'b0;
        steps(3);
        #1;
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Flush with one queued entry and two slow reads in flight.
        do_reset(32'h4);
        imem_gnt_i = 1'b1;
        step();
        mem_lat = 10;
        steps(2);
        #1;
        check("flush_pre_count", 64'(count_o), 64'd1);
        check("flush_pre_req", 64'(imem_req_o), 64'd0);
        flush_i = 1'b1; pc_i = 32'h40; dec_ready_i = 1'b1;
        expect_decode(32'h40, 32'hA5A5_0040);
        #1;
        check("flush_dec_valid_forced", 64'(dec_valid_o), 64'd0);
        mem_lat = 1;
        step();
        flush_i = 1'b0;
        #1;
        check("flush_count_cleared", 64'(count_o), 64'd0);
        check("flush_dec_valid_after", 64'(dec_valid_o), 64'd0);
        k = 0;
        while (halt_o && k < 20) begin
            step();
            #1;
            k++;
        end
        check("flush_target_granted", 64'(k < 20), 64'd1);
        step();
        imem_gnt_i = 1'b0;
        steps(3);
        #1;
        check("flush_drained", 64'(exp_q.size()), 64'd0);

        // Flush in the same cycle as a response and a ready decode.
        do_reset(32'h200);
        imem_gnt_i = 1'b1; dec_ready_i = 1'b1;
        steps(2);
        flush_i = 1'b1; pc_i = 32'h300;
        expect_decode(32'h300, 32'hA5A5_0300);
        #1;
        check("frv_count_before", 64'(count_o), 64'd1);
        check("frv_dec_valid", 64'(dec_valid_o), 64'd0);
        check("frv_target_req", 64'(imem_req_o), 64'd1);
        check("frv_target_addr", 64'(imem_addr_o), 64'h300);
        step();
        flush_i = 1'b0; imem_gnt_i = 1'b0;
        #1;
        check("frv_count_after", 64'(count_o), 64'd0);
        steps(3);
        #1;
        check("frv_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a stream.
        do_reset(32'h500);
        imem_gnt_i = 1'b1; dec_ready_i = 1'b1;
        expect_decode(32'h500, 32'hA5A5_0500);
        steps(3);
        #1;
        check("areset_pre_drained", 64'(exp_q.size()), 64'd0);
        #1;
        rst = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        mem_q.delete();
        exp_q.delete();
        #1 check_reset_outputs("areset");
        pc_i = 32'h0;
        step();
        rst = 1'b1;
        #1;
        check("areset_first_req", 64'(imem_req_o), 64'd1);
        check("areset_first_addr", 64'(imem_addr_o), 64'd0);
        imem_gnt_i = 1'b1;
        expect_decode(32'h0, 32'hA5A5_0000);
        step();
        imem_gnt_i = 1'b0;
        steps(3);
        #1;
        check("areset_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
